// File: rtl/ps2_mouse_host_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ps2_mouse_host_ctrl_pkg
//   Shared constants and types for the host-side PS/2 mouse controller:
//   host command bytes, device reply bytes, host-controller FSM state
//   encoding and a small saturating-increment helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package ps2_mouse_host_ctrl_pkg;

   // Host -> device commands
   localparam logic [7:0] PS2_CMD_RESET_CMD       = 8'hFF;
   localparam logic [7:0] PS2_CMD_SET_STREAM_MODE = 8'hEA;
   localparam logic [7:0] PS2_CMD_ENABLE_REPORT   = 8'hF4;

   // Device -> host replies
   localparam logic [7:0] PS2_RD_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RD_PASS   = 8'hAA;
   localparam logic [7:0] PS2_RD_RESEND = 8'hFE;
   localparam logic [7:0] PS2_RD_ERROR  = 8'hFC;

   // Host-controller FSM states. The encoding is visible on the fsm_state
   // debug port, so keep it stable.
   typedef enum logic [3:0] {
      ST_SEND_RESET   = 4'd0,
      ST_WAIT_ACK_RST = 4'd1,
      ST_WAIT_BAT     = 4'd2,
      ST_WAIT_ID      = 4'd3,
      ST_SEND_STREAM  = 4'd4,
      ST_WAIT_ACK_STR = 4'd5,
      ST_SEND_ENABLE  = 4'd6,
      ST_WAIT_ACK_EN  = 4'd7,
      ST_PKT_B1       = 4'd8,
      ST_PKT_B2       = 4'd9,
      ST_PKT_B3       = 4'd10,
      ST_ERROR        = 4'd11
   } host_state_t;

   // 8-bit increment that sticks at 0xFF.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/ps2_mouse_host_ctrl_resp_timer.sv
// ---------------------------------------------------------------------------
// ps2_mouse_host_ctrl_resp_timer
//   32-bit up-counter with synchronous clear and a terminal-count compare.
//   The count sticks at all-ones so a very long idle period cannot wrap
//   around and drop the expired indication.
// Ports
//   clk      in   1   system clock
//   rst      in   1   synchronous, active-high reset
//   clr      in   1   restart counting from zero on the next edge
//   limit    in  32   terminal count; expired while count >= limit
//   expired  out  1   count has reached limit
// ---------------------------------------------------------------------------
module ps2_mouse_host_ctrl_resp_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic [31:0] limit,
   output logic        expired
);

   logic [31:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (count != '1) begin
         count <= count + 32'd1;
      end
   end

   assign expired = (count >= limit);

endmodule

// File: rtl/ps2_mouse_host_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_mouse_host_ctrl
//   Host-side PS/2 mouse controller sitting above the rx/tx PHY. Runs the
//   init handshake (reset, self-test, ID, stream mode, enable reporting),
//   then frames 3-byte movement packets into signed dx/dy and buttons.
//   Handles resend requests, init retries and response/byte-gap timeouts.
//
// Handshake to the PHY: tx_stb is a single-cycle write that is only issued
//   while tx_ready=1; the byte is considered accepted on that cycle and the
//   controller then waits for the tx_done pulse. rx_done is a single-cycle
//   qualifier for rx_data with no back-pressure.
//
// Ports
//   clk           in   1  system clock
//   rst           in   1  synchronous, active-high reset
//   reinit        in   1  pulse: abort and restart init, retry count cleared
//   tx_data       out  8  command byte to PHY
//   tx_stb        out  1  one-cycle write strobe to PHY
//   tx_ready      in   1  PHY can accept tx_stb
//   tx_done       in   1  PHY finished sending a byte
//   rx_data       in   8  received byte
//   rx_done       in   1  rx_data valid
//   init_done     out  1  init complete, streaming active
//   error         out  1  retries exhausted or 0xFC received
//   device_id     out  8  ID byte captured after self-test
//   packet_valid  out  1  pulse: dx/dy/buttons updated this cycle
//   buttons       out  3  {middle,right,left}
//   dx, dy        out  9  two's-complement movement {sign,byte}
//   x_ovf, y_ovf  out  1  overflow bits of last packet
//   sync_err_cnt  out  8  saturating count of discarded bytes/packets
//   fsm_state     out  4  current FSM state (debug)
// ---------------------------------------------------------------------------
module ps2_mouse_host_ctrl
   import ps2_mouse_host_ctrl_pkg::*;
#(
   parameter logic [31:0] RESP_TIMEOUT_CYCLES = 32'd1_000_000,
   parameter logic [31:0] BYTE_GAP_CYCLES     = 32'd100_000,
   parameter int          MAX_RETRIES         = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       reinit,
   output logic [7:0] tx_data,
   output logic       tx_stb,
   input  logic       tx_ready,
   input  logic       tx_done,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   output logic       init_done,
   output logic       error,
   output logic [7:0] device_id,
   output logic       packet_valid,
   output logic [2:0] buttons,
   output logic [8:0] dx,
   output logic [8:0] dy,
   output logic       x_ovf,
   output logic       y_ovf,
   output logic [7:0] sync_err_cnt,
   output logic [3:0] fsm_state
);

   localparam logic [7:0] MAX_RETRY_CNT = 8'(MAX_RETRIES);

   host_state_t state, state_nxt;
   logic        sent;        // strobe issued in the current SEND state
   logic        retry_req;   // init attempt failed this cycle
   logic [7:0]  retry_cnt;
   logic [31:0] timer_limit;
   logic        timer_clr;
   logic        timeout;
   logic        sync_inc;

   // First packet byte, held until the third byte completes the packet.
   logic [2:0]  hdr_btn;
   logic        hdr_xs, hdr_ys, hdr_xo, hdr_yo;
   logic [7:0]  b2_q;

   assign fsm_state = state;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_SEND_RESET;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- next-state logic ----------------
   // Priority: reinit, then rx_done, then timeout. Bytes arriving in a SEND
   // state are ignored because those states never look at rx_done.
   always_comb begin
      state_nxt = state;
      retry_req = 1'b0;
      if (reinit) begin
         state_nxt = ST_SEND_RESET;
      end else begin
         unique case (state)
            ST_SEND_RESET:  if (sent && tx_done) state_nxt = ST_WAIT_ACK_RST;
            ST_SEND_STREAM: if (sent && tx_done) state_nxt = ST_WAIT_ACK_STR;
            ST_SEND_ENABLE: if (sent && tx_done) state_nxt = ST_WAIT_ACK_EN;

            ST_WAIT_ACK_RST: begin
               if (rx_done) begin
                  if (rx_data == PS2_RD_ACK)         state_nxt = ST_WAIT_BAT;
                  else if (rx_data == PS2_RD_RESEND) state_nxt = ST_SEND_RESET;
                  else if (rx_data == PS2_RD_ERROR)  state_nxt = ST_ERROR;
                  else                               retry_req = 1'b1;
               end else if (timeout) begin
                  retry_req = 1'b1;
               end
            end

            ST_WAIT_ACK_STR: begin
               if (rx_done) begin
                  if (rx_data == PS2_RD_ACK)         state_nxt = ST_SEND_ENABLE;
                  else if (rx_data == PS2_RD_RESEND) state_nxt = ST_SEND_STREAM;
                  else if (rx_data == PS2_RD_ERROR)  state_nxt = ST_ERROR;
                  else                               retry_req = 1'b1;
               end else if (timeout) begin
                  retry_req = 1'b1;
               end
            end

            ST_WAIT_ACK_EN: begin
               if (rx_done) begin
                  if (rx_data == PS2_RD_ACK)         state_nxt = ST_PKT_B1;
                  else if (rx_data == PS2_RD_RESEND) state_nxt = ST_SEND_ENABLE;
                  else if (rx_data == PS2_RD_ERROR)  state_nxt = ST_ERROR;
                  else                               retry_req = 1'b1;
               end else if (timeout) begin
                  retry_req = 1'b1;
               end
            end

            ST_WAIT_BAT: begin
               if (rx_done) begin
                  if (rx_data == PS2_RD_PASS) state_nxt = ST_WAIT_ID;
                  else                        retry_req = 1'b1;
               end else if (timeout) begin
                  retry_req = 1'b1;
               end
            end

            ST_WAIT_ID: begin
               if (rx_done)      state_nxt = ST_SEND_STREAM;
               else if (timeout) retry_req = 1'b1;
            end

            // Bit 3 of a real first byte is always 1; anything else is
            // treated as lost framing and discarded in place.
            ST_PKT_B1: if (rx_done && rx_data[3]) state_nxt = ST_PKT_B2;

            ST_PKT_B2: begin
               if (rx_done)      state_nxt = ST_PKT_B3;
               else if (timeout) state_nxt = ST_PKT_B1;
            end

            ST_PKT_B3: begin
               if (rx_done || timeout) state_nxt = ST_PKT_B1;
            end

            ST_ERROR: state_nxt = ST_ERROR;

            default: state_nxt = ST_SEND_RESET;
         endcase

         if (retry_req) begin
            state_nxt = (retry_cnt == MAX_RETRY_CNT) ? ST_ERROR : ST_SEND_RESET;
         end
      end
   end

   // ---------------- output logic ----------------
   always_comb begin
      tx_data     = 8'h00;
      tx_stb      = 1'b0;
      timer_limit = RESP_TIMEOUT_CYCLES;
      error       = (state == ST_ERROR);
      unique case (state)
         ST_SEND_RESET: begin
            tx_data = PS2_CMD_RESET_CMD;
            tx_stb  = !sent && tx_ready;
         end
         ST_SEND_STREAM: begin
            tx_data = PS2_CMD_SET_STREAM_MODE;
            tx_stb  = !sent && tx_ready;
         end
         ST_SEND_ENABLE: begin
            tx_data = PS2_CMD_ENABLE_REPORT;
            tx_stb  = !sent && tx_ready;
         end
         ST_PKT_B2, ST_PKT_B3: timer_limit = BYTE_GAP_CYCLES;
         default: ;
      endcase
      // Keep the PHY interface quiet while reset is held.
      if (rst) begin
         tx_data = 8'h00;
         tx_stb  = 1'b0;
         error   = 1'b0;
      end
   end

   // ---------------- strobe tracking and retry counter ----------------
   always_ff @(posedge clk) begin
      if (rst || reinit || (state_nxt != state)) begin
         sent <= 1'b0;
      end else if (tx_stb) begin
         sent <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || reinit) begin
         retry_cnt <= 8'd0;
      end else if (retry_req && (retry_cnt != MAX_RETRY_CNT)) begin
         retry_cnt <= retry_cnt + 8'd1;
      end
   end

   // ---------------- response / byte-gap timer ----------------
   assign timer_clr = reinit || rx_done || (state_nxt != state);

   ps2_mouse_host_ctrl_resp_timer u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (timer_clr),
      .limit   (timer_limit),
      .expired (timeout)
   );

   // ---------------- capture registers ----------------
   // A discarded byte in PKT_B1 and a dropped partial packet both count
   // as one sync error.
   assign sync_inc = !reinit &&
                     (((state == ST_PKT_B1) && rx_done && !rx_data[3]) ||
                      (((state == ST_PKT_B2) || (state == ST_PKT_B3)) && !rx_done && timeout));

   always_ff @(posedge clk) begin
      if (rst) begin
         init_done    <= 1'b0;
         device_id    <= 8'h00;
         packet_valid <= 1'b0;
         buttons      <= 3'b000;
         dx           <= 9'h000;
         dy           <= 9'h000;
         x_ovf        <= 1'b0;
         y_ovf        <= 1'b0;
         sync_err_cnt <= 8'h00;
         hdr_btn      <= 3'b000;
         hdr_xs       <= 1'b0;
         hdr_ys       <= 1'b0;
         hdr_xo       <= 1'b0;
         hdr_yo       <= 1'b0;
         b2_q         <= 8'h00;
      end else begin
         packet_valid <= 1'b0;

         if (sync_inc) begin
            sync_err_cnt <= sat_inc8(sync_err_cnt);
         end

         if (reinit || (state_nxt == ST_ERROR)) begin
            init_done <= 1'b0;
         end else if ((state == ST_WAIT_ACK_EN) && (state_nxt == ST_PKT_B1)) begin
            init_done <= 1'b1;
         end

         if (!reinit && rx_done) begin
            if (state == ST_WAIT_ID) begin
               device_id <= rx_data;
            end
            if ((state == ST_PKT_B1) && rx_data[3]) begin
               hdr_yo  <= rx_data[7];
               hdr_xo  <= rx_data[6];
               hdr_ys  <= rx_data[5];
               hdr_xs  <= rx_data[4];
               hdr_btn <= rx_data[2:0];
            end
            if (state == ST_PKT_B2) begin
               b2_q <= rx_data;
            end
            if (state == ST_PKT_B3) begin
               buttons      <= hdr_btn;
               x_ovf        <= hdr_xo;
               y_ovf        <= hdr_yo;
               dx           <= {hdr_xs, b2_q};
               dy           <= {hdr_ys, rx_data};
               packet_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_mouse_host_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ps2_mouse_host_ctrl
//   Directed bench for ps2_mouse_host_ctrl. A small PHY model accepts
//   tx_stb, holds tx_ready low for a few cycles, pulses tx_done and logs the
//   byte; scenario tasks play the device side through rx_data/rx_done.
// ---------------------------------------------------------------------------
module tb_ps2_mouse_host_ctrl;

   localparam logic [31:0] RESP_TO  = 32'd200;
   localparam logic [31:0] GAP_TO   = 32'd50;
   localparam int          MAX_RTRY = 3;
   localparam int          TX_LAT   = 3;

   logic       clk, rst, reinit;
   logic [7:0] tx_data;
   logic       tx_stb, tx_ready, tx_done;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       init_done, error, packet_valid, x_ovf, y_ovf;
   logic [7:0] device_id, sync_err_cnt;
   logic [2:0] buttons;
   logic [8:0] dx, dy;
   logic [3:0] fsm_state;

   int n_checks = 0;
   int n_errors = 0;
   int pv_cnt   = 0;
   logic [7:0] tx_q[$];

   ps2_mouse_host_ctrl #(
      .RESP_TIMEOUT_CYCLES (RESP_TO),
      .BYTE_GAP_CYCLES     (GAP_TO),
      .MAX_RETRIES         (MAX_RTRY)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .reinit       (reinit),
      .tx_data      (tx_data),
      .tx_stb       (tx_stb),
      .tx_ready     (tx_ready),
      .tx_done      (tx_done),
      .rx_data      (rx_data),
      .rx_done      (rx_done),
      .init_done    (init_done),
      .error        (error),
      .device_id    (device_id),
      .packet_valid (packet_valid),
      .buttons      (buttons),
      .dx           (dx),
      .dy           (dy),
      .x_ovf        (x_ovf),
      .y_ovf        (y_ovf),
      .sync_err_cnt (sync_err_cnt),
      .fsm_state    (fsm_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- PHY model ----------------
   initial begin
      logic [7:0] b;
      tx_ready = 1'b1;
      tx_done  = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_stb === 1'b1) begin
            b = tx_data;
            @(posedge clk); #1 tx_ready = 1'b0;
            repeat (TX_LAT) @(posedge clk);
            #1 tx_done = 1'b1;
            @(posedge clk); #1 tx_done = 1'b0;
            tx_ready = 1'b1;
            tx_q.push_back(b);
         end
      end
   end

   // packet_valid pulse counter
   always @(negedge clk) begin
      if (packet_valid === 1'b1) pv_cnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic send_rx(input logic [7:0] b);
      @(posedge clk); #1 rx_data = b; rx_done = 1'b1;
      @(posedge clk); #1 rx_done = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_reinit();
      @(posedge clk); #1 reinit = 1'b1;
      @(posedge clk); #1 reinit = 1'b0;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Waits (bounded) for the PHY to complete a byte and compares it.
   task automatic expect_tx(input logic [7:0] exp, input string what, input int budget);
      int n;
      logic [7:0] got;
      n = 0;
      while (tx_q.size() == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (tx_q.size() == 0) begin
         n_errors++;
         $display("FAIL %s: no byte sent within %0d cycles, expected 0x%02h", what, budget, exp);
      end else begin
         got = tx_q.pop_front();
         if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: sent 0x%02h, expected 0x%02h", what, got, exp);
         end
      end
   endtask

   // Plays a clean device through init with the given ID byte.
   task automatic run_init(input logic [7:0] id);
      expect_tx(8'hFF, "init_reset_cmd", 50);
      send_rx(8'hFA);
      send_rx(8'hAA);
      send_rx(id);
      expect_tx(8'hEA, "init_stream_cmd", 50);
      send_rx(8'hFA);
      expect_tx(8'hF4, "init_enable_cmd", 50);
      send_rx(8'hFA);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if ({init_done, error, packet_valid, tx_stb} !== 4'b0000) begin
         n_errors++;
         $display("FAIL reset_flags: got %b, expected 0000", {init_done, error, packet_valid, tx_stb});
      end
      n_checks++;
      if ({tx_data, device_id, sync_err_cnt} !== 24'h0) begin
         n_errors++;
         $display("FAIL reset_bytes: got %h, expected 000000", {tx_data, device_id, sync_err_cnt});
      end
      n_checks++;
      if ({buttons, dx, dy, x_ovf, y_ovf} !== 23'h0) begin
         n_errors++;
         $display("FAIL reset_packet: got %h, expected 0", {buttons, dx, dy, x_ovf, y_ovf});
      end
      n_checks++;
      if (fsm_state !== 4'd0) begin
         n_errors++;
         $display("FAIL reset_state: got %0d, expected 0", fsm_state);
      end
   endtask

   task automatic test_init();
      run_init(8'h89);
      n_checks++;
      if (init_done !== 1'b1 || error !== 1'b0) begin
         n_errors++;
         $display("FAIL init_flags: init_done=%b error=%b, expected 1/0", init_done, error);
      end
      n_checks++;
      if (device_id !== 8'h89) begin
         n_errors++;
         $display("FAIL init_id: got 0x%02h, expected 0x89", device_id);
      end
      n_checks++;
      if (fsm_state !== 4'd8) begin
         n_errors++;
         $display("FAIL init_state: got %0d, expected 8", fsm_state);
      end
   endtask

   task automatic test_stream();
      int pv0;
      pv0 = pv_cnt;
      send_rx(8'h19);
      send_rx(8'h12);
      send_rx(8'h82);
      idle(2);
      n_checks++;
      if (pv_cnt !== pv0 + 1) begin
         n_errors++;
         $display("FAIL stream_pulses: got %0d, expected %0d", pv_cnt - pv0, 1);
      end
      n_checks++;
      if (buttons !== 3'b001 || dx !== 9'h112 || dy !== 9'h082 || x_ovf !== 1'b0 || y_ovf !== 1'b0) begin
         n_errors++;
         $display("FAIL stream_data: btn=%b dx=%h dy=%h ovf=%b%b, expected 001 112 082 00",
                  buttons, dx, dy, y_ovf, x_ovf);
      end
   endtask

   task automatic test_sync_loss();
      int pv0;
      pv0 = pv_cnt;
      send_rx(8'h12);
      n_checks++;
      if (sync_err_cnt !== 8'd1 || fsm_state !== 4'd8) begin
         n_errors++;
         $display("FAIL sync_drop: cnt=%0d state=%0d, expected 1/8", sync_err_cnt, fsm_state);
      end
      send_rx(8'h19);
      send_rx(8'h12);
      send_rx(8'h82);
      idle(2);
      n_checks++;
      if (pv_cnt !== pv0 + 1 || dx !== 9'h112 || dy !== 9'h082) begin
         n_errors++;
         $display("FAIL sync_packet: pulses=%0d dx=%h dy=%h, expected 1 112 082", pv_cnt - pv0, dx, dy);
      end
   endtask

   task automatic test_gap();
      int pv0;
      // Idling in PKT_B1 longer than the gap limit must not count an error.
      idle(100);
      n_checks++;
      if (sync_err_cnt !== 8'd1) begin
         n_errors++;
         $display("FAIL gap_idle_b1: cnt=%0d, expected 1", sync_err_cnt);
      end
      pv0 = pv_cnt;
      send_rx(8'h19);
      idle(60);
      n_checks++;
      if (sync_err_cnt !== 8'd2 || pv_cnt !== pv0 || fsm_state !== 4'd8) begin
         n_errors++;
         $display("FAIL gap_drop: cnt=%0d pulses=%0d state=%0d, expected 2 0 8",
                  sync_err_cnt, pv_cnt - pv0, fsm_state);
      end
      send_rx(8'hEE);
      send_rx(8'h05);
      send_rx(8'hF0);
      idle(2);
      n_checks++;
      if (pv_cnt !== pv0 + 1 || buttons !== 3'b110 || dx !== 9'h005 || dy !== 9'h1F0 ||
          x_ovf !== 1'b1 || y_ovf !== 1'b1) begin
         n_errors++;
         $display("FAIL gap_next: pulses=%0d btn=%b dx=%h dy=%h ovf=%b%b, expected 1 110 005 1f0 11",
                  pv_cnt - pv0, buttons, dx, dy, y_ovf, x_ovf);
      end
   endtask

   task automatic test_resend();
      pulse_reinit();
      n_checks++;
      if (init_done !== 1'b0) begin
         n_errors++;
         $display("FAIL resend_reinit: init_done=%b, expected 0", init_done);
      end
      expect_tx(8'hFF, "resend_reset_cmd", 50);
      send_rx(8'hFA);
      send_rx(8'hAA);
      send_rx(8'h5A);
      expect_tx(8'hEA, "resend_stream_first", 50);
      send_rx(8'hFE);
      expect_tx(8'hEA, "resend_stream_again", 50);
      send_rx(8'hFA);
      expect_tx(8'hF4, "resend_enable_cmd", 50);
      send_rx(8'hFA);
      n_checks++;
      if (init_done !== 1'b1 || error !== 1'b0 || device_id !== 8'h5A) begin
         n_errors++;
         $display("FAIL resend_done: init_done=%b error=%b id=0x%02h, expected 1 0 0x5a",
                  init_done, error, device_id);
      end
   endtask

   task automatic test_timeout();
      pulse_reinit();
      // Original attempt plus MAX_RTRY restarts, all unanswered.
      for (int i = 0; i <= MAX_RTRY; i++) begin
         expect_tx(8'hFF, "timeout_reset_cmd", 300);
      end
      idle(150);
      n_checks++;
      if (error !== 1'b0) begin
         n_errors++;
         $display("FAIL timeout_early: error=%b, expected 0", error);
      end
      idle(100);
      n_checks++;
      if (error !== 1'b1 || init_done !== 1'b0 || fsm_state !== 4'd11) begin
         n_errors++;
         $display("FAIL timeout_error: error=%b init_done=%b state=%0d, expected 1 0 11",
                  error, init_done, fsm_state);
      end
      idle(400);
      n_checks++;
      if (tx_q.size() !== 0) begin
         n_errors++;
         $display("FAIL timeout_silent: %0d bytes sent, expected 0", tx_q.size());
      end
      // reinit leaves ERROR; an 0xFC reply goes straight back to it.
      pulse_reinit();
      n_checks++;
      if (error !== 1'b0) begin
         n_errors++;
         $display("FAIL timeout_reinit: error=%b, expected 0", error);
      end
      expect_tx(8'hFF, "fc_reset_cmd", 50);
      send_rx(8'hFC);
      n_checks++;
      if (error !== 1'b1) begin
         n_errors++;
         $display("FAIL fc_error: error=%b, expected 1", error);
      end
      pulse_reinit();
      run_init(8'h89);
      n_checks++;
      if (init_done !== 1'b1 || error !== 1'b0) begin
         n_errors++;
         $display("FAIL timeout_recover: init_done=%b error=%b, expected 1 0", init_done, error);
      end
   endtask

   task automatic test_rst_mid_bat();
      pulse_reinit();
      expect_tx(8'hFF, "rst_bat_reset_cmd", 50);
      send_rx(8'hFA);
      n_checks++;
      if (fsm_state !== 4'd2) begin
         n_errors++;
         $display("FAIL rst_bat_state: got %0d, expected 2", fsm_state);
      end
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({init_done, error, packet_valid, device_id, sync_err_cnt, dx, dy, buttons} !== 42'h0) begin
         n_errors++;
         $display("FAIL rst_bat_outputs: id=0x%02h sync=%0d dx=%h dy=%h btn=%b, expected all 0",
                  device_id, sync_err_cnt, dx, dy, buttons);
      end
      @(posedge clk); #1 rst = 1'b0;
      expect_tx(8'hFF, "rst_bat_resend", 50);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst     = 1'b1;
      reinit  = 1'b0;
      rx_data = 8'h00;
      rx_done = 1'b0;
      repeat (3) @(posedge clk);
      test_reset();
      @(posedge clk); #1 rst = 1'b0;
      test_init();
      test_stream();
      test_sync_loss();
      test_gap();
      test_resend();
      test_timeout();
      test_rst_mid_bat();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Hard stop in case a wait ever escapes its budget.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
